alu_issue_arbiter: RTL

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_issue_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// Two-thread ALU issue arbiter: packs 32-bit pairs, round-robins 64-bit ops; optional stats under ALU_ISSUE_ARB_STATS_EN.
// Latency 1 cycle from accept strobe to iss_valid; issue slot holds while iss_ready=0 and no requests are accepted.
module alu_issue_arbiter #(
   parameter int unsigned PAIR_WAIT = 2,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic             a_is64,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic             b_is64,
   output logic             b_ready,
   output logic             iss_valid,
   input  logic             iss_ready,
   output logic             iss_mode,
   output logic             iss_sel,
   output logic             iss_lane_a,
   output logic             iss_lane_b
`ifdef ALU_ISSUE_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] pack_cnt,
   output logic [CNT_W-1:0] solo_cnt
`endif
);

   localparam int unsigned WC_W = $clog2(PAIR_WAIT + 2);

   typedef enum logic {IDLE, PWAIT} state_t;

   state_t          state, state_nxt;
   logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
   logic            wait_b;
   logic            rr, rr_nxt;
   logic            slot_free, lone_a32, lone_b32, lone32, hold_lone, wait_done;
   logic            mode_nxt, sel_nxt, lane_a_nxt, lane_b_nxt;

   assign slot_free = !iss_valid || iss_ready;
   assign lone_a32  = a_valid && !a_is64 && !b_valid;
   assign lone_b32  = b_valid && !b_is64 && !a_valid;
   assign lone32    = lone_a32 || lone_b32;
   // A different thread taking over the lone slot restarts the wait from scratch.
   assign hold_lone = lone32 && (state == IDLE || lone_b32 == wait_b);
   assign wait_done = (wait_cnt == WC_W'(PAIR_WAIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         wait_b   <= 1'b0;
         rr       <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         rr       <= rr_nxt;
         if (slot_free) wait_b <= lone_b32;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      rr_nxt       = rr;
      if (slot_free) begin
         if (hold_lone && !wait_done) begin
            state_nxt    = PWAIT;
            wait_cnt_nxt = wait_cnt + WC_W'(1);
         end else begin
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
         end
         if (a_valid && b_valid && (a_is64 || b_is64)) rr_nxt = !rr;
      end
   end

   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (slot_free && !rst) begin
         if (a_valid && b_valid) begin
            if (!a_is64 && !b_is64) begin
               a_ready = 1'b1;
               b_ready = 1'b1;
            end else if (!rr) begin
               a_ready = 1'b1;
            end else begin
               b_ready = 1'b1;
            end
         end else if (a_valid) begin
            a_ready = a_is64 || (hold_lone && wait_done);
         end else if (b_valid) begin
            b_ready = b_is64 || (hold_lone && wait_done);
         end
      end
   end

   // A packed grant only ever involves two 32-bit ops, so these cover all cases.
   assign mode_nxt   = (a_ready && a_is64) || (b_ready && b_is64);
   assign sel_nxt    = b_ready && b_is64;
   assign lane_a_nxt = a_ready && !a_is64;
   assign lane_b_nxt = b_ready && !b_is64;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_valid  <= 1'b0;
         iss_mode   <= 1'b0;
         iss_sel    <= 1'b0;
         iss_lane_a <= 1'b0;
         iss_lane_b <= 1'b0;
      end else if (slot_free) begin
         iss_valid  <= a_ready || b_ready;
         iss_mode   <= mode_nxt;
         iss_sel    <= sel_nxt;
         iss_lane_a <= lane_a_nxt;
         iss_lane_b <= lane_b_nxt;
      end
   end

`ifdef ALU_ISSUE_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pack_cnt <= '0;
         solo_cnt <= '0;
      end else begin
         if (a_ready && b_ready && !(&pack_cnt)) pack_cnt <= pack_cnt + CNT_W'(1);
         if ((a_ready ^ b_ready) && !(&solo_cnt)) solo_cnt <= solo_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
